addr_sequencer: RTL and testbench

Parametrised address sequencer. It generates a memory/register address that advances one step per enabled clock, with four run modes, a runtime upper bound, synchronous load, and a one-hot decoded select bus. It sits between the control logic and the storage it scans. It is the generalised successor of the fixed 4-state, 2-bit up-counting address FSM.

---
 rtl/addr_sequencer_pkg.sv | 31 +++
 rtl/addr_sequencer_decoder.sv | 23 ++
 rtl/addr_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_addr_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/addr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// addr_seq_pkg
// Shared encodings for the address sequencer slice.
//   mode_t  : run-mode encodings, matching the 2-bit Mode input
//   state_t : sequencer FSM state (RUN / STOP)
// ---------------------------------------------------------------------------
package addr_seq_pkg;

  // Run modes as presented on the Mode input.
  typedef enum logic [1:0] {
    MODE_UP_WRAP   = 2'b00,
    MODE_DOWN_WRAP = 2'b01,
    MODE_PING_PONG = 2'b10,
    MODE_ONE_SHOT  = 2'b11
  } mode_t;

  // RUN allows advancing; STOP is entered when a ONE_SHOT run completes
  // and is left only through Load or reset.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_STOP = 1'b1
  } state_t;

  // Direction flag values.
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest supported address; the select bus is 2**ADDR_W bits wide.
  localparam int ADDR_W_MAX = 8;

endpackage : addr_seq_pkg

// File: rtl/addr_sequencer_decoder.sv
// ---------------------------------------------------------------------------
// addr_decoder
// Purely combinational one-hot decoder from a binary address.
//   Address in  [ADDR_W-1:0]       binary address
//   Select  out [2**ADDR_W-1:0]    Select[i] = 1 iff Address == i
// Exactly one Select bit is high for any defined Address.
// ---------------------------------------------------------------------------
module addr_decoder
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]         Address,
  output logic [(1<<ADDR_W)-1:0]    Select
);

  localparam int SEL_W = 1 << ADDR_W;

  for (genvar gi = 0; gi < SEL_W; gi++) begin : g_sel
    assign Select[gi] = (Address == ADDR_W'(gi));
  end

endmodule : addr_decoder

// File: rtl/addr_sequencer.sv
// ---------------------------------------------------------------------------
// addr_sequencer
// Address generator that steps once per enabled clock in one of four run
// modes (up-wrap, down-wrap, ping-pong, one-shot) within 0..Limit, with a
// synchronous clamped load and a one-hot decoded select bus.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   W         in   wait; advance only when W==0
//   Mode      in   [1:0] run mode (see addr_seq_pkg::mode_t)
//   Limit     in   [ADDR_W-1:0] inclusive upper bound of the range
//   Load      in   load strobe; beats advance and ignores W
//   LoadValue in   [ADDR_W-1:0] value loaded (clamped to Limit)
//   Address   out  [ADDR_W-1:0] current address (registered)
//   Select    out  [2**ADDR_W-1:0] one-hot decode of Address
//   Dir       out  direction, 0 up / 1 down (registered)
//   Wrap      out  one-cycle pulse after a wrap or turnaround step
//   Done      out  sticky ONE_SHOT completion flag
// ---------------------------------------------------------------------------
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      W,
  input  logic [1:0]                Mode,
  input  logic [ADDR_W-1:0]         Limit,
  input  logic                      Load,
  input  logic [ADDR_W-1:0]         LoadValue,
  output logic [ADDR_W-1:0]         Address,
  output logic [(1<<ADDR_W)-1:0]    Select,
  output logic                      Dir,
  output logic                      Wrap,
  output logic                      Done
);

  // -------------------------------------------------------------------------
  // State registers and their next values
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_reg,  addr_next;
  logic              dir_reg,   dir_next;
  logic              wrap_reg,  wrap_next;
  logic              done_reg,  done_next;
  state_t            state_reg, state_next;

  mode_t             mode_s;

  // Precomputed ADDR_W-bit arithmetic shared by the mode rules.
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] addr_dec;
  logic [ADDR_W-1:0] load_clamped;
  logic [ADDR_W-1:0] pp_top_turn;   // address after turning down at the top
  logic [ADDR_W-1:0] pp_bot_turn;   // address after turning up at zero
  logic              limit_is_zero;

  assign mode_s        = mode_t'(Mode);
  assign addr_inc      = addr_reg + ADDR_W'(1);
  assign addr_dec      = addr_reg - ADDR_W'(1);
  assign load_clamped  = (LoadValue > Limit) ? Limit : LoadValue;
  assign limit_is_zero = (Limit == '0);

  // With a zero-width range the ping-pong turnaround collapses onto 0.
  assign pp_top_turn   = limit_is_zero ? '0 : (Limit - ADDR_W'(1));
  assign pp_bot_turn   = limit_is_zero ? '0 : ADDR_W'(1);

  // -------------------------------------------------------------------------
  // Next-state / next-address logic
  // Priority: Load > advance (W==0, RUN) > hold. Wrap is a single-cycle
  // pulse, so it defaults low every edge.
  // -------------------------------------------------------------------------
  always_comb begin
    addr_next  = addr_reg;
    dir_next   = dir_reg;
    wrap_next  = 1'b0;
    done_next  = done_reg;
    state_next = state_reg;

    if (Load) begin
      addr_next  = load_clamped;
      dir_next   = (mode_s == MODE_DOWN_WRAP) ? DIR_DOWN : DIR_UP;
      done_next  = 1'b0;
      state_next = ST_RUN;
    end else if (!W && (state_reg == ST_RUN)) begin
      unique case (mode_s)
        MODE_UP_WRAP: begin
          // >= rather than == so an address left above a lowered Limit
          // wraps straight back to 0.
          if (addr_reg >= Limit) begin
            addr_next = '0;
            wrap_next = 1'b1;
          end else begin
            addr_next = addr_inc;
          end
        end

        MODE_DOWN_WRAP: begin
          if (addr_reg == '0) begin
            addr_next = Limit;
            wrap_next = 1'b1;
          end else if (addr_reg > Limit) begin
            // Out of range after a Limit change: re-enter at the top
            // without reporting a wrap.
            addr_next = Limit;
          end else begin
            addr_next = addr_dec;
          end
        end

        MODE_PING_PONG: begin
          if (dir_reg == DIR_UP) begin
            if (addr_reg >= Limit) begin
              dir_next  = DIR_DOWN;
              addr_next = pp_top_turn;
              wrap_next = 1'b1;
            end else begin
              addr_next = addr_inc;
            end
          end else begin
            if (addr_reg == '0) begin
              dir_next  = DIR_UP;
              addr_next = pp_bot_turn;
              wrap_next = 1'b1;
            end else begin
              addr_next = addr_dec;
            end
          end
        end

        MODE_ONE_SHOT: begin
          // The addr_reg >= Limit term covers the case where addr_inc has
          // wrapped past the top of the ADDR_W range.
          if ((addr_inc >= Limit) || (addr_reg >= Limit)) begin
            addr_next  = Limit;
            done_next  = 1'b1;
            state_next = ST_STOP;
          end else begin
            addr_next = addr_inc;
          end
        end

        default: begin
          addr_next = addr_reg;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      addr_reg  <= '0;
      dir_reg   <= DIR_UP;
      wrap_reg  <= 1'b0;
      done_reg  <= 1'b0;
      state_reg <= ST_RUN;
    end else begin
      addr_reg  <= addr_next;
      dir_reg   <= dir_next;
      wrap_reg  <= wrap_next;
      done_reg  <= done_next;
      state_reg <= state_next;
    end
  end

  assign Address = addr_reg;
  assign Dir     = dir_reg;
  assign Wrap    = wrap_reg;
  assign Done    = done_reg;

  // -------------------------------------------------------------------------
  // One-hot select, decoded straight from the address register so it is
  // valid during reset as well.
  // -------------------------------------------------------------------------
  addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_decoder (
    .Address (addr_reg),
    .Select  (Select)
  );

endmodule : addr_sequencer

// File: tb/tb_addr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_addr_sequencer
// Directed scenarios followed by randomized stimulus, all checked against a
// behavioural model of the sequencing rules (ADDR_W = 3).
// ---------------------------------------------------------------------------
module tb_addr_sequencer;

  localparam int AW = 3;

  logic          Clock;
  logic          Reset;
  logic          W;
  logic [1:0]    Mode;
  logic [AW-1:0] Limit;
  logic          Load;
  logic [AW-1:0] LoadValue;
  logic [AW-1:0] Address;
  logic [7:0]    Select;
  logic          Dir;
  logic          Wrap;
  logic          Done;

  addr_sequencer #(.ADDR_W(AW)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .W         (W),
    .Mode      (Mode),
    .Limit     (Limit),
    .Load      (Load),
    .LoadValue (LoadValue),
    .Address   (Address),
    .Select    (Select),
    .Dir       (Dir),
    .Wrap      (Wrap),
    .Done      (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_addr;
  int m_dir;
  int m_wrap;
  int m_done;
  int m_stop;

  task automatic model_reset();
    m_addr = 0; m_dir = 0; m_wrap = 0; m_done = 0; m_stop = 0;
  endtask

  // Applies one rising edge worth of the sequencing rules to the model,
  // using the inputs currently driven.
  task automatic model_edge();
    int lim;
    int a;
    lim = int'(Limit);
    a   = m_addr;
    m_wrap = 0;
    if (Load) begin
      m_addr = (int'(LoadValue) < lim) ? int'(LoadValue) : lim;
      m_dir  = (Mode == 2'd1) ? 1 : 0;
      m_done = 0;
      m_stop = 0;
    end else if (!W && !m_stop) begin
      case (Mode)
        2'd0: if (a >= lim) begin m_addr = 0; m_wrap = 1; end
              else m_addr = a + 1;
        2'd1: if (a == 0) begin m_addr = lim; m_wrap = 1; end
              else if (a > lim) m_addr = lim;
              else m_addr = a - 1;
        2'd2: if (m_dir == 0) begin
                if (a >= lim) begin
                  m_dir = 1; m_wrap = 1; m_addr = (lim == 0) ? 0 : lim - 1;
                end else m_addr = a + 1;
              end else begin
                if (a == 0) begin
                  m_dir = 0; m_wrap = 1; m_addr = (lim == 0) ? 0 : 1;
                end else m_addr = a - 1;
              end
        default: if (a + 1 >= lim) begin
                   m_addr = lim; m_done = 1; m_stop = 1;
                 end else m_addr = a + 1;
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] exp_sel;
    exp_sel = 8'd1 << m_addr;
    chk({tag, ".addr"}, 32'(Address), 32'(m_addr));
    chk({tag, ".sel"},  32'(Select),  32'(exp_sel));
    chk({tag, ".dir"},  32'(Dir),     32'(m_dir));
    chk({tag, ".wrap"}, 32'(Wrap),    32'(m_wrap));
    chk({tag, ".done"}, 32'(Done),    32'(m_done));
  endtask

  // One clock: model the edge, let the DUT take it, check 1 ns later.
  task automatic cycle(input string tag);
    model_edge();
    @(posedge Clock);
    #1;
    $display("[%0t] %s mode=%0d lim=%0d W=%0b ld=%0b lv=%0d -> addr=%0d dir=%0b wrap=%0b done=%0b",
             $time, tag, Mode, Limit, W, Load, LoadValue, Address, Dir, Wrap, Done);
    check_all(tag);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic reset_pulse(input string tag);
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    check_all(tag);
    #1;
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b0; W = 1'b1; Mode = 2'd0; Limit = 3'd5; Load = 1'b0; LoadValue = '0;
    model_reset();
    #3;
    check_all("reset");
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // UP_WRAP, Limit 5
    Mode = 2'd0; Limit = 3'd5; W = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      cycle("up");
      if (i == 5) chk("up_sel5", 32'(Select), 32'h20);
      if (i == 6) begin
        chk("up_wrap_addr", 32'(Address), 32'd0);
        chk("up_wrap_pulse", 32'(Wrap), 32'd1);
      end
    end

    // PING_PONG, Limit 3, from reset
    reset_pulse("pp_rst");
    Mode = 2'd2; Limit = 3'd3; W = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cycle("pp");
      if (i == 4) begin
        chk("pp_turn_addr", 32'(Address), 32'd2);
        chk("pp_turn_dir", 32'(Dir), 32'd1);
      end
    end

    // ONE_SHOT, Limit 4, then reload
    reset_pulse("os_rst");
    Mode = 2'd3; Limit = 3'd4; W = 1'b0;
    for (int i = 1; i <= 8; i++) cycle("os");
    chk("os_hold_addr", 32'(Address), 32'd4);
    chk("os_hold_done", 32'(Done), 32'd1);
    Load = 1'b1; LoadValue = 3'd1;
    cycle("os_load");
    chk("os_reload_addr", 32'(Address), 32'd1);
    chk("os_reload_done", 32'(Done), 32'd0);
    Load = 1'b0;
    for (int i = 1; i <= 4; i++) cycle("os2");

    // DOWN_WRAP with clamped load and a wait window
    Mode = 2'd1; Limit = 3'd5; Load = 1'b1; LoadValue = 3'd7;
    cycle("dn_load");
    chk("dn_clamp_addr", 32'(Address), 32'd5);
    chk("dn_clamp_dir", 32'(Dir), 32'd1);
    Load = 1'b0; W = 1'b0;
    for (int i = 1; i <= 3; i++) cycle("dn");
    W = 1'b1;
    for (int i = 1; i <= 3; i++) cycle("dn_wait");
    chk("dn_frozen", 32'(Address), 32'd2);
    W = 1'b0;
    for (int i = 1; i <= 4; i++) cycle("dn2");

    // Load beats advance; lowered Limit wraps on next advance
    Mode = 2'd0; Limit = 3'd7; Load = 1'b1; LoadValue = 3'd4;
    cycle("ld4");
    LoadValue = 3'd2; W = 1'b0;
    cycle("ld_vs_adv");
    chk("ld_wins", 32'(Address), 32'd2);
    LoadValue = 3'd4;
    cycle("ld4b");
    Load = 1'b0; Limit = 3'd1;
    cycle("lim_drop");
    chk("lim_drop_addr", 32'(Address), 32'd0);
    chk("lim_drop_wrap", 32'(Wrap), 32'd1);

    // Async reset at Address 6, between edges
    Limit = 3'd7; Load = 1'b1; LoadValue = 3'd6;
    cycle("ld6");
    Load = 1'b0; W = 1'b1;
    #2;
    Reset = 1'b0;
    model_reset();
    #1;
    chk("arst_addr", 32'(Address), 32'd0);
    chk("arst_sel", 32'(Select), 32'h01);
    check_all("arst");
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      W    = ($urandom_range(0, 3) == 0);
      Load = ($urandom_range(0, 15) == 0);
      LoadValue = 3'($urandom);
      if ($urandom_range(0, 19) == 0) Mode  = 2'($urandom);
      if ($urandom_range(0, 24) == 0) Limit = 3'($urandom);
      if (i == 200) reset_pulse("rand_rst");
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_addr_sequencer
